// File: rtl/nms_ctrl_pkg.sv
// rtl/nms_ctrl_pkg.sv - shared types and constants for the NMS frame sequencer
package nms_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int BYP_TOP   = 0;
  localparam int BYP_BOT   = 1;
  localparam int BYP_LEFT  = 2;
  localparam int BYP_RIGHT = 3;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } sideband_t;

endpackage

// File: rtl/nms_frame_ctrl_if.sv
// rtl/nms_frame_ctrl_if.sv - input/output pixel stream handshake bundle
interface nms_frame_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_sof;
  logic out_eol;
  logic out_eof;

  modport master (
    input  in_valid,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_sof,
    output out_eol,
    output out_eof
  );

  modport slave (
    output in_valid,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_sof,
    input  out_eol,
    input  out_eof
  );
endinterface

// File: rtl/nms_pos_cnt.sv
// rtl/nms_pos_cnt.sv - raster row/column counter with wrap at (H-1, W-1)
module nms_pos_cnt #(
  parameter int COL_W = 12,
  parameter int ROW_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [COL_W-1:0] width,
  input  logic [ROW_W-1:0] height,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic last_col;

  assign last_col = (col == width - COL_W'(1));
  assign last     = last_col && (row == height - ROW_W'(1));

  // step through the raster, wrapping back to (0,0) after the final pixel
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/nms_frame_ctrl.sv
// rtl/nms_frame_ctrl.sv - NMS frame sequencer; NMS_STATS_EN adds the edge pixel counter
module nms_frame_ctrl
  import nms_ctrl_pkg::*;
#(
  parameter int COL_W = 12,
  parameter int ROW_W = 12,
  parameter int CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [COL_W-1:0]  cfg_width,
  input  logic [ROW_W-1:0]  cfg_height,
  nms_frame_ctrl_if.master  bus,
  output logic              win_shift,
  output logic [3:0]        bypass,
  input  logic              nms_mask_in,
  output logic              busy,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  edge_count
);

  state_t state, state_nxt;

  logic [COL_W-1:0] w_reg;
  logic [ROW_W-1:0] h_reg;
  logic [COL_W-1:0] in_col, ctr_col;
  logic [ROW_W-1:0] in_row, ctr_row;
  logic             in_last, ctr_last;
  logic             cfg_ok, start_go, adv, accept, out_hs, ctr_valid;
  logic             flush_done, s1_fresh;
  sideband_t        s1_sb, out_sb;

  assign cfg_ok    = (cfg_width >= COL_W'(2)) && (cfg_height >= ROW_W'(2));
  assign start_go  = start && (state == IDLE) && cfg_ok;
  assign adv       = !bus.out_valid || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;
  assign out_hs    = bus.out_valid && bus.out_ready;
  // once FILL has loaded W+1 pixels every further shift forms a window with a real centre
  assign ctr_valid = (state == RUN) || (state == FLUSH);

  nms_pos_cnt #(.COL_W(COL_W), .ROW_W(ROW_W)) u_in_pos (
    .clk(clk), .rst_n(rst_n), .clr(start_go), .en(accept),
    .width(w_reg), .height(h_reg), .col(in_col), .row(in_row), .last(in_last)
  );

  nms_pos_cnt #(.COL_W(COL_W), .ROW_W(ROW_W)) u_ctr_pos (
    .clk(clk), .rst_n(rst_n), .clr(start_go), .en(win_shift && ctr_valid),
    .width(w_reg), .height(h_reg), .col(ctr_col), .row(ctr_row), .last(ctr_last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: fill W+1 pixels, run to the last input, flush until the eof result leaves
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_go) state_nxt = FILL;
      FILL:  if (accept && in_row == ROW_W'(1) && in_col == '0) state_nxt = RUN;
      RUN:   if (accept && in_last) state_nxt = FLUSH;
      FLUSH: if (out_hs && bus.out_eof) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded handshake and shift controls
  always_comb begin
    bus.in_ready = adv && (state == FILL || state == RUN);
    win_shift    = adv && ((bus.in_valid && (state == FILL || state == RUN)) ||
                           (state == FLUSH && !flush_done));
    busy         = (state != IDLE);
  end

  // frame geometry, config error pulse and the end-of-flush marker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_reg      <= '0;
      h_reg      <= '0;
      cfg_err    <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      cfg_err <= start && (state == IDLE) && !cfg_ok;
      if (start_go) begin
        w_reg      <= cfg_width;
        h_reg      <= cfg_height;
        flush_done <= 1'b0;
      end else if (win_shift && state == FLUSH && ctr_last) begin
        flush_done <= 1'b1;
      end
    end
  end

  // stage 1: bypass and sideband follow the window; s1_fresh marks an unconsumed centre
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bypass   <= '0;
      s1_sb    <= '0;
      s1_fresh <= 1'b0;
    end else begin
      if (win_shift) begin
        bypass[BYP_TOP]   <= (ctr_row == '0);
        bypass[BYP_BOT]   <= (ctr_row == h_reg - ROW_W'(1));
        bypass[BYP_LEFT]  <= (ctr_col == '0);
        bypass[BYP_RIGHT] <= (ctr_col == w_reg - COL_W'(1));
        s1_sb.sof         <= (ctr_row == '0) && (ctr_col == '0);
        s1_sb.eol         <= (ctr_col == w_reg - COL_W'(1));
        s1_sb.eof         <= ctr_last;
      end
      if (adv) s1_fresh <= win_shift && ctr_valid;
    end
  end

  // stage 2: valid/sideband aligned with the kernel register, held while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      out_sb        <= '0;
    end else if (adv) begin
      bus.out_valid <= s1_fresh;
      out_sb        <= s1_sb;
    end
  end

  assign bus.out_sof = out_sb.sof;
  assign bus.out_eol = out_sb.eol;
  assign bus.out_eof = out_sb.eof;

`ifdef NMS_STATS_EN
  logic [CNT_W-1:0] edge_acc, acc_nxt, edge_cnt_r;

  // saturating count of accepted outputs flagged as edges
  always_comb begin
    acc_nxt = edge_acc;
    if (out_hs && nms_mask_in && !(&edge_acc)) acc_nxt = edge_acc + CNT_W'(1);
  end

  // accumulate over the frame and publish the total at the eof handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_acc   <= '0;
      edge_cnt_r <= '0;
    end else begin
      edge_acc <= start_go ? '0 : acc_nxt;
      if (out_hs && bus.out_eof) edge_cnt_r <= acc_nxt;
    end
  end

  assign edge_count = edge_cnt_r;
`else
  logic unused_mask;
  assign unused_mask = nms_mask_in;
  assign edge_count  = '0;
`endif

endmodule

// File: tb/tb_nms_frame_ctrl.sv
// tb/tb_nms_frame_ctrl.sv - scoreboard bench for nms_frame_ctrl
module tb_nms_frame_ctrl;
  import nms_ctrl_pkg::*;

`ifdef NMS_STATS_EN
  localparam int EXP_EDGES = 5;
`else
  localparam int EXP_EDGES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] cfg_width = '0;
  logic [11:0] cfg_height = '0;
  logic        win_shift;
  logic [3:0]  bypass;
  logic        nms_mask_in = 1'b0;
  logic        busy;
  logic        cfg_err;
  logic [23:0] edge_count;

  nms_frame_ctrl_if bus ();

  nms_frame_ctrl #(.COL_W(12), .ROW_W(12), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .bus(bus), .win_shift(win_shift), .bypass(bypass),
    .nms_mask_in(nms_mask_in), .busy(busy), .cfg_err(cfg_err),
    .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [2:0] exp_out[$];
  logic [3:0] exp_byp[$];
  logic [3:0] byp_log[$];

  int n_out, n_acc, n_shift, n_zero, first_out_cyc, sixth_cyc, cur_w;
  int n_cfg_err, n_busy_seen, n_rdy_seen;
  bit mon_en = 1'b0;
  bit ready_tog = 1'b0;
  bit mask_mode = 1'b0;
  bit byp_pend = 1'b0;
  bit stall_pend = 1'b0;
  logic [2:0] held;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus.out_ready = ready_tog ? ~bus.out_ready : 1'b1;
    nms_mask_in   = mask_mode && (n_out < 5);
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (byp_pend) begin
        byp_pend = 1'b0;
        if (exp_byp.size() == 0) fail_now("bypass_extra");
        else begin
          chk("bypass", bypass, exp_byp.pop_front());
          byp_log.push_back(bypass);
        end
      end
      if (stall_pend) begin
        stall_pend = 1'b0;
        chk("stall_valid_held", bus.out_valid, 1);
        chk("stall_sideband_held", {bus.out_sof, bus.out_eol, bus.out_eof}, held);
      end
      if (bus.out_valid) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        if (bus.out_ready) begin
          if (exp_out.size() == 0) fail_now("extra_output");
          else chk("sideband", {bus.out_sof, bus.out_eol, bus.out_eof}, exp_out.pop_front());
          n_out++;
        end else begin
          stall_pend = 1'b1;
          held = {bus.out_sof, bus.out_eol, bus.out_eof};
        end
      end
      if (win_shift) begin
        n_shift++;
        if (!bus.in_ready) n_zero++;
        if (n_shift == cur_w + 2) sixth_cyc = cyc;
        if (n_shift >= cur_w + 2) byp_pend = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) n_acc++;
    end
    if (cfg_err) n_cfg_err++;
    if (busy) n_busy_seen++;
    if (bus.in_ready) n_rdy_seen++;
  end

  task automatic run_frame(input int w, input int h, input bit tog, input bit mask, input int abort_at);
    int t;
    cur_w = w; n_out = 0; n_acc = 0; n_shift = 0; n_zero = 0;
    first_out_cyc = -1; sixth_cyc = -1;
    byp_log.delete();
    stall_pend = 1'b0; byp_pend = 1'b0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        exp_out.push_back({r == 0 && c == 0, c == w - 1, r == h - 1 && c == w - 1});
        exp_byp.push_back({c == w - 1, c == 0, r == h - 1, r == 0});
      end
    ready_tog = tog; mask_mode = mask; mon_en = 1'b1;
    @(posedge clk); #1;
    cfg_width = 12'(w); cfg_height = 12'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b1;
    for (t = 0; t < 3000; t++) begin
      if (n_acc >= w * h) bus.in_valid = 1'b0;
      if (abort_at > 0 && n_acc >= abort_at) break;
      if (!busy) break;
      @(posedge clk); #1;
    end
    if (t >= 3000) fail_now("frame_timeout");
    bus.in_valid = 1'b0;
    ready_tog = 1'b0; mask_mode = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_win_shift", win_shift, 0);
    chk("rst_bypass", bypass, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_edge_count", edge_count, 0);
    chk("rst_sideband", {bus.out_sof, bus.out_eol, bus.out_eof}, 0);

    // 4x3 frame, downstream always ready
    run_frame(4, 3, 1'b0, 1'b0, 0);
    chk("a_outputs", n_out, 12);
    chk("a_exp_left", exp_out.size(), 0);
    chk("a_byp_left", exp_byp.size(), 0);
    chk("a_latency", first_out_cyc - sixth_cyc, 2);
    chk("a_zero_shifts", n_zero, 5);
    chk("a_busy_end", busy, 0);
    if (byp_log.size() != 12) fail_now("a_byp_log_size");
    else begin
      chk("a_byp_0_0", byp_log[0], 4'b0101);
      chk("a_byp_0_3", byp_log[3], 4'b1001);
      chk("a_byp_1_1", byp_log[5], 4'b0000);
      chk("a_byp_2_0", byp_log[8], 4'b0110);
      chk("a_byp_2_3", byp_log[11], 4'b1010);
    end

    // same frame with out_ready toggling every cycle
    run_frame(4, 3, 1'b1, 1'b0, 0);
    chk("b_outputs", n_out, 12);
    chk("b_exp_left", exp_out.size(), 0);
    chk("b_byp_left", exp_byp.size(), 0);

    // minimum 2x2 frame
    run_frame(2, 2, 1'b0, 1'b0, 0);
    chk("c_outputs", n_out, 4);
    chk("c_zero_shifts", n_zero, 3);
    chk("c_total_shifts", n_shift, 7);
    chk("c_busy_end", busy, 0);
    chk("c_exp_left", exp_out.size(), 0);

    // rejected geometries
    for (int k = 0; k < 2; k++) begin
      n_cfg_err = 0; n_busy_seen = 0; n_rdy_seen = 0;
      @(posedge clk); #1;
      cfg_width = (k == 0) ? 12'd1 : 12'd5;
      cfg_height = (k == 0) ? 12'd5 : 12'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      chk("cfg_err_pulses", n_cfg_err, 1);
      chk("cfg_err_busy", n_busy_seen, 0);
      chk("cfg_err_in_ready", n_rdy_seen, 0);
    end

    // reset after 7 pixels, then a clean frame
    run_frame(4, 3, 1'b0, 1'b0, 7);
    chk("abort_accepts", n_acc, 7);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bypass", bypass, 0);
    exp_out.delete();
    exp_byp.delete();
    run_frame(4, 3, 1'b0, 1'b0, 0);
    chk("d_outputs", n_out, 12);
    chk("d_exp_left", exp_out.size(), 0);

    // edge statistics: 5 flagged outputs, then none
    run_frame(4, 3, 1'b0, 1'b1, 0);
    chk("e_outputs", n_out, 12);
    chk("e_edge_count", edge_count, EXP_EDGES);
    run_frame(4, 3, 1'b0, 1'b0, 0);
    chk("f_edge_count", edge_count, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
